integral_pixel_feeder: RTL and testbench

Write-side driver for `IntegralBuffer`. On a `Start` pulse it scans a binary image of `ImageHeight` rows × `ImageWidth` columns out of a 1-bit pixel memory in row-major order. It then drives `IntegralBuffer`'s `WriteEnable`/`Addr`/`Data` port with one single-cycle write per pixel, spaced by a programmable gap. It replaces the hand-written pixel stimulus used so far and sits between the frame store and the integral buffer.

---
 rtl/integral_pkg.sv | 24 ++
 rtl/integral_scan_counter.sv | 55 +++++
 rtl/integral_pixel_feeder.sv | 103 ++++++++++
 tb/tb_integral_pixel_feeder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integral_pkg.sv
// Shared FSM state type and width helpers for the integral-image write path.
// IntegralBuffer uses addr_width() as well, so the two blocks always agree on Addr width.
package integral_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      WRITE,
      GAP,
      NEXT,
      DONE
   } state_t;

   // Column address width; wide enough to hold ImageWidth itself, as IntegralBuffer does.
   function automatic int unsigned addr_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   function automatic int unsigned mem_width(input int unsigned width, input int unsigned height);
      return (width * height < 2) ? 1 : $clog2(width * height);
   endfunction

endpackage

// File: rtl/integral_scan_counter.sv
// Row-major scan position: column, row and linear pixel index, stepped together.
// The linear index drives the pixel memory directly, so no multiplier is needed.
module integral_scan_counter
   import integral_pkg::*;
#(
   parameter int unsigned ImageWidth  = 7,
   parameter int unsigned ImageHeight = 5
) (
   input  logic                                          Clock,
   input  logic                                          Reset,
   input  logic                                          Clear,
   input  logic                                          Step,
   output logic [addr_width(ImageWidth)-1:0]             Col,
   output logic [mem_width(ImageWidth, ImageHeight)-1:0] Linear,
   output logic                                          LastCol,
   output logic                                          LastPix
);

   localparam int unsigned AW = addr_width(ImageWidth);
   localparam int unsigned MW = mem_width(ImageWidth, ImageHeight);
   localparam int unsigned RW = addr_width(ImageHeight);
   localparam logic [AW-1:0] COL_LAST = AW'(ImageWidth - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ImageHeight - 1);

   logic [AW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [MW-1:0] r_linear;
   logic          w_last_col;
   logic          w_last_row;

   assign w_last_col = (r_col == COL_LAST);
   assign w_last_row = (r_row == ROW_LAST);

   always_ff @(posedge Clock) begin
      if (Reset || Clear) begin
         r_col    <= '0;
         r_row    <= '0;
         r_linear <= '0;
      end else if (Step) begin
         if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + AW'(1);
         end
         r_linear <= (w_last_col && w_last_row) ? '0 : r_linear + MW'(1);
      end
   end

   assign Col     = r_col;
   assign Linear  = r_linear;
   assign LastCol = w_last_col;
   assign LastPix = w_last_col && w_last_row;

endmodule

// File: rtl/integral_pixel_feeder.sv
// Scans a 1-bit frame store in row-major order and issues one spaced single-cycle
// write per pixel into IntegralBuffer (column address + pixel bit).
module integral_pixel_feeder
   import integral_pkg::*;
#(
   parameter int unsigned ImageWidth  = 7,
   parameter int unsigned ImageHeight = 5,
   parameter int unsigned GapCycles   = 3
) (
   input  logic                                          Clock,
   input  logic                                          Reset,
   input  logic                                          Start,
   input  logic                                          Pause,
   output logic                                          PixRead,
   output logic [mem_width(ImageWidth, ImageHeight)-1:0] PixAddr,
   input  logic                                          PixData,
   output logic                                          WriteEnable,
   output logic [addr_width(ImageWidth)-1:0]             Addr,
   output logic                                          Data,
   output logic                                          Busy,
   output logic                                          RowDone,
   output logic                                          FrameDone
);

   localparam int unsigned AW = addr_width(ImageWidth);
   localparam int unsigned MW = mem_width(ImageWidth, ImageHeight);
   localparam int unsigned GW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GapCycles > 0) ? GapCycles - 1 : 0);

   state_t        r_state;
   logic [GW-1:0] r_gap;
   logic [AW-1:0] r_addr;
   logic          r_data;

   logic [AW-1:0] w_col;
   logic [MW-1:0] w_linear;
   logic          w_last_col;
   logic          w_last_pix;
   logic          w_clear;
   logic          w_step;

   // Counters restart on every accepted Start and advance only when heading back to FETCH.
   assign w_clear = (r_state == IDLE) && Start;
   assign w_step  = (r_state == NEXT) && !w_last_pix && !Pause;

   integral_scan_counter #(
      .ImageWidth (ImageWidth),
      .ImageHeight(ImageHeight)
   ) u_scan (
      .Clock  (Clock),
      .Reset  (Reset),
      .Clear  (w_clear),
      .Step   (w_step),
      .Col    (w_col),
      .Linear (w_linear),
      .LastCol(w_last_col),
      .LastPix(w_last_pix)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= IDLE;
         r_gap   <= '0;
         r_addr  <= '0;
         r_data  <= 1'b0;
      end else begin
         case (r_state)
            IDLE:  if (Start) r_state <= FETCH;
            FETCH: r_state <= LATCH;
            LATCH: begin
               // Memory data is valid here; Addr/Data load only on entry to WRITE and hold after.
               r_state <= WRITE;
               r_addr  <= w_col;
               r_data  <= PixData;
            end
            WRITE: begin
               r_gap   <= '0;
               r_state <= (GapCycles == 0) ? NEXT : GAP;
            end
            GAP: begin
               if (r_gap == GAP_LAST) r_state <= NEXT;
               else                   r_gap   <= r_gap + GW'(1);
            end
            NEXT: begin
               if (w_last_pix)  r_state <= DONE;
               else if (!Pause) r_state <= FETCH;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign PixRead     = (r_state == FETCH);
   assign PixAddr     = w_linear;
   assign WriteEnable = (r_state == WRITE);
   assign RowDone     = (r_state == WRITE) && w_last_col;
   assign FrameDone   = (r_state == DONE);
   assign Busy        = (r_state != IDLE);
   assign Addr        = r_addr;
   assign Data        = r_data;

endmodule

// File: tb/tb_integral_pixel_feeder.sv
// Self-checking bench for integral_pixel_feeder: a G=3 instance exercised across several
// frames (pause, restart, mid-frame reset) and a G=0 instance, against a timing/value model.
module tb_integral_pixel_feeder;

   localparam int W  = 7;
   localparam int H  = 5;
   localparam int N  = W * H;
   localparam int MW = 6;
   localparam int AW = 3;

   typedef struct {
      int cyc;
      int addr;
      int data;
      int rd;
   } wev_t;

   typedef struct {
      int cyc;
      int addr;
   } rev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   bit   mem[64];

   logic          start_a, pause_a, rd_a, pd_a, we_a, data_a, busy_a, rowdone_a, fd_a;
   logic [MW-1:0] pixaddr_a;
   logic [AW-1:0] addr_a;
   logic          start_b, pause_b, rd_b, pd_b, we_b, data_b, busy_b, rowdone_b, fd_b;
   logic [MW-1:0] pixaddr_b;
   logic [AW-1:0] addr_b;

   wev_t wqa[$];
   rev_t rqa[$];
   int   fqa[$];
   int   viola;
   logic prev_we_a;
   wev_t wqb[$];
   rev_t rqb[$];
   int   fqb[$];
   int   violb;
   logic prev_we_b;

   integral_pixel_feeder #(
      .ImageWidth (W),
      .ImageHeight(H),
      .GapCycles  (3)
   ) dut_a (
      .Clock      (clk),
      .Reset      (rst),
      .Start      (start_a),
      .Pause      (pause_a),
      .PixRead    (rd_a),
      .PixAddr    (pixaddr_a),
      .PixData    (pd_a),
      .WriteEnable(we_a),
      .Addr       (addr_a),
      .Data       (data_a),
      .Busy       (busy_a),
      .RowDone    (rowdone_a),
      .FrameDone  (fd_a)
   );

   integral_pixel_feeder #(
      .ImageWidth (W),
      .ImageHeight(H),
      .GapCycles  (0)
   ) dut_b (
      .Clock      (clk),
      .Reset      (rst),
      .Start      (start_b),
      .Pause      (pause_b),
      .PixRead    (rd_b),
      .PixAddr    (pixaddr_b),
      .PixData    (pd_b),
      .WriteEnable(we_b),
      .Addr       (addr_b),
      .Data       (data_b),
      .Busy       (busy_b),
      .RowDone    (rowdone_b),
      .FrameDone  (fd_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame store: data valid the cycle after a read strobe, garbage otherwise.
   always @(posedge clk) begin
      pd_a <= rd_a ? mem[pixaddr_a] : 1'($urandom);
      pd_b <= rd_b ? mem[pixaddr_b] : 1'($urandom);
   end

   initial begin
      viola = 0; violb = 0; prev_we_a = 1'b0; prev_we_b = 1'b0;
   end

   always @(negedge clk) begin : mon
      wev_t we;
      rev_t re;
      if (we_a) begin
         we.cyc = cyc; we.addr = int'(addr_a); we.data = int'(data_a); we.rd = int'(rowdone_a);
         wqa.push_back(we);
      end
      if (rd_a) begin
         re.cyc = cyc; re.addr = int'(pixaddr_a);
         rqa.push_back(re);
      end
      if (fd_a) fqa.push_back(cyc);
      if ((we_a && prev_we_a) || (we_a && rd_a)) viola++;
      prev_we_a = we_a;
      if (we_b) begin
         we.cyc = cyc; we.addr = int'(addr_b); we.data = int'(data_b); we.rd = int'(rowdone_b);
         wqb.push_back(we);
      end
      if (rd_b) begin
         re.cyc = cyc; re.addr = int'(pixaddr_b);
         rqb.push_back(re);
      end
      if (fd_b) fqb.push_back(cyc);
      if ((we_b && prev_we_b) || (we_b && rd_b)) violb++;
      prev_we_b = we_b;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic clear_a();
      wqa.delete(); rqa.delete(); fqa.delete(); viola = 0;
   endtask

   task automatic clear_b();
      wqb.delete(); rqb.delete(); fqb.delete(); violb = 0;
   endtask

   // Called at a negedge while idle; returns the cycle in which FETCH is expected.
   task automatic do_start_a(output int f0);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      f0 = cyc;
   endtask

   task automatic do_start_b(output int f0);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      f0 = cyc;
   endtask

   task automatic fill_random();
      for (int k = 0; k < N; k++) mem[k] = 1'($urandom_range(0, 1));
   endtask

   // Each pixel takes `per` cycles; a pause of `pl` cycles after pixel `pp` shifts all later pixels.
   task automatic check_frame(input bit use_b, input int f0, input int per, input int pp, input int pl);
      wev_t cw[$];
      rev_t cr[$];
      int   cf[$];
      int   v;
      int   et;
      if (use_b) begin
         cw = wqb; cr = rqb; cf = fqb; v = violb;
      end else begin
         cw = wqa; cr = rqa; cf = fqa; v = viola;
      end
      chk("write_count", cw.size(), N);
      chk("read_count", cr.size(), N);
      chk("framedone_count", cf.size(), 1);
      if (cf.size() > 0) chk("framedone_cycle", cf[0] - f0, N * per + pl);
      chk("strobe_overlap", v, 0);
      for (int k = 0; k < N; k++) begin
         et = f0 + k * per + ((pl > 0 && k > pp) ? pl : 0);
         if (k < cr.size()) begin
            chk($sformatf("read_cyc[%0d]", k), cr[k].cyc - f0, et - f0);
            chk($sformatf("pixaddr[%0d]", k), cr[k].addr, (k / W) * W + (k % W));
         end
         if (k < cw.size()) begin
            chk($sformatf("write_cyc[%0d]", k), cw[k].cyc - f0, et + 2 - f0);
            chk($sformatf("addr[%0d]", k), cw[k].addr, k % W);
            chk($sformatf("data[%0d]", k), cw[k].data, int'(mem[k]));
            chk($sformatf("rowdone[%0d]", k), cw[k].rd, int'((k % W) == W - 1));
         end
      end
   endtask

   initial begin
      int f0, d, pp, pl, rc;
      total = 0; bad = 0;
      rst = 1'b1; start_a = 1'b0; pause_a = 1'b0; start_b = 1'b0; pause_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_a", int'({rd_a, pixaddr_a, we_a, addr_a, data_a, busy_a, rowdone_a, fd_a}), 0);
      chk("reset_b", int'({rd_b, pixaddr_b, we_b, addr_b, data_b, busy_b, rowdone_b, fd_b}), 0);
      rst = 1'b0;
      @(negedge clk);

      // All-ones frame, with a Start pulse mid-frame that must be ignored.
      for (int k = 0; k < N; k++) mem[k] = 1'b1;
      clear_a();
      do_start_a(f0);
      chk("first_fetch_rd", int'(rd_a), 1);
      chk("first_fetch_addr", int'(pixaddr_a), 0);
      chk("busy_after_start", int'(busy_a), 1);
      wait_until(f0 + 50);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_until(f0 + N * 7);
      chk("framedone_pulse", int'(fd_a), 1);
      chk("busy_in_done", int'(busy_a), 1);
      @(negedge clk);
      chk("busy_drop", int'(busy_a), 0);
      check_frame(1'b0, f0, 7, 0, 0);

      // Checkerboard frame with a 10-cycle pause in the NEXT after pixel 3.
      for (int k = 0; k < N; k++) mem[k] = 1'(((k / W) + (k % W)) & 1);
      clear_a();
      do_start_a(f0);
      wait_until(f0 + 4 * 7 - 1);
      pause_a = 1'b1;
      repeat (10) @(negedge clk);
      pause_a = 1'b0;
      d = f0 + N * 7 + 10;
      wait_until(d);
      chk("framedone_after_pause", int'(fd_a), 1);
      @(negedge clk);
      chk("busy_drop_2", int'(busy_a), 0);
      check_frame(1'b0, f0, 7, 3, 10);

      // Start in the IDLE cycle right after FrameDone, random data and random pause.
      fill_random();
      pp = $urandom_range(0, N - 2);
      pl = $urandom_range(1, 8);
      clear_a();
      do_start_a(f0);
      chk("restart_latency", f0 - d, 2);
      wait_until(f0 + pp * 7 + 6);
      pause_a = 1'b1;
      repeat (pl) @(negedge clk);
      pause_a = 1'b0;
      wait_until(f0 + N * 7 + pl + 1);
      check_frame(1'b0, f0, 7, pp, pl);

      // Reset during the gap of pixel 12, then a clean rescan.
      fill_random();
      clear_a();
      do_start_a(f0);
      rc = f0 + 12 * 7 + 3;
      wait_until(rc);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_mid_frame", int'({rd_a, pixaddr_a, we_a, addr_a, data_a, busy_a, rowdone_a, fd_a}), 0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("writes_before_reset", wqa.size(), 13);
      chk("no_framedone_after_reset", fqa.size(), 0);
      chk("idle_after_reset", int'(busy_a), 0);
      clear_a();
      do_start_a(f0);
      chk("rescan_addr0", int'(pixaddr_a), 0);
      wait_until(f0 + N * 7 + 1);
      check_frame(1'b0, f0, 7, 0, 0);

      // Zero-gap instance: 4-cycle pixel period, 140-cycle frame.
      fill_random();
      clear_b();
      do_start_b(f0);
      wait_until(f0 + N * 4 + 1);
      check_frame(1'b1, f0, 4, 0, 0);
      chk("busy_b_idle", int'(busy_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
